// File: rtl/sync_bank.sv
// Bank of independent multi-flop synchronizers with an optional per-channel debounce filter,
// dout edge pulses, and a reset synchronizer that asserts asynchronously and releases on clk.
module sync_bank #(
    parameter int                 WIDTH     = 4,
    parameter int                 STAGES    = 2,
    parameter int                 FILTER    = 0,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             rst_sync_n
);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_bank: WIDTH must be 1 or more");
    end
    if (STAGES < 2) begin : g_bad_stages
        $error("sync_bank: STAGES must be 2 or more");
    end
    if (FILTER < 0) begin : g_bad_filter
        $error("sync_bank: FILTER must be 0 or more");
    end

    // Counter width is only meaningful when the filter exists; keep it legal otherwise.
    localparam int CW = (FILTER > 0) ? $clog2(FILTER + 1) : 1;

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             s;
    logic [WIDTH-1:0]             level;
    logic [WIDTH-1:0]             dprev;
    logic [STAGES-1:0]            rst_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[STAGES-1];

    if (FILTER == 0) begin : g_bypass
        assign level = s;
    end else begin : g_filter
        localparam logic [CW-1:0] LAST = CW'(FILTER - 1);

        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            logic [CW-1:0] cnt;
            logic          lvl;

            // A disagreement must persist for FILTER consecutive samples; any agreement restarts it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt <= '0;
                    lvl <= RESET_VAL[i];
                end else if (s[i] == lvl) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt <= '0;
                    lvl <= s[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign level[i] = lvl;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dprev <= RESET_VAL;
        end else begin
            dprev <= level;
        end
    end

    // Reset forces level and dprev equal, so no pulse survives or follows a reset.
    assign dout = level;
    assign rise = level & ~dprev;
    assign fall = ~level & dprev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_q <= '0;
        end else begin
            rst_q <= {rst_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = rst_q[STAGES-1];

endmodule

// File: tb/tb_sync_bank.sv
// Bench for sync_bank: a FILTER=3 instance checked against a hand-derived vector table and
// reset sequences, plus a FILTER=0 instance checked against a two-edge delay model.
module tb_sync_bank;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] din_a, din_b;
  logic [W-1:0] dout_a, rise_a, fall_a;
  logic [W-1:0] dout_b, rise_b, fall_b;
  logic         rsn_a, rsn_b;

  int           n_vec = 0;
  int           n_bad = 0;
  logic [11:0]  exp_q[$];
  logic [11:0]  exp_b_q[$];
  vec_t         vecs[$];
  logic [W-1:0] prev_din_b;
  logic [W-1:0] prev_dout_b;

  sync_bank #(.WIDTH(W), .STAGES(2), .FILTER(3), .RESET_VAL(4'b0000)) dut_a (
    .clk(clk), .reset_n(reset_n), .din(din_a), .dout(dout_a),
    .rise(rise_a), .fall(fall_a), .rst_sync_n(rsn_a)
  );

  sync_bank #(.WIDTH(W), .STAGES(2), .FILTER(0), .RESET_VAL(4'b0000)) dut_b (
    .clk(clk), .reset_n(reset_n), .din(din_b), .dout(dout_b),
    .rise(rise_b), .fall(fall_b), .rst_sync_n(rsn_b)
  );

  // clock / reset
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // driver / scoreboard helpers
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic add_run(input int n, input logic [W-1:0] d, input logic [W-1:0] o,
                         input logic [W-1:0] r, input logic [W-1:0] f);
    vec_t v;
    v.din = d; v.dout = o; v.rise = r; v.fall = f;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  // FILTER=0 reference: dout is the din driven one row earlier, pulses from its own history.
  task automatic push_b(input logic [W-1:0] d);
    logic [W-1:0] o;
    o = prev_din_b;
    exp_b_q.push_back({o, o & ~prev_dout_b, ~o & prev_dout_b});
    prev_dout_b = o;
    prev_din_b  = d;
  endtask

  task automatic pop_check(input string name, input logic [11:0] got_a, input logic [11:0] got_b);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_a_empty"}, 16'h1, 16'h0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_a"}, {4'h0, got_a}, {4'h0, e});
    end
    if (exp_b_q.size() == 0) begin
      check({name, "_b_empty"}, 16'h1, 16'h0);
    end else begin
      e = exp_b_q.pop_front();
      check({name, "_b"}, {4'h0, got_b}, {4'h0, e});
    end
  endtask

  initial begin
    // stimulus table: rise ch0, glitch ch1, held ch1, ch2 rise, simultaneous fall ch2+ch0,
    // ch1 fall, then a ch3 pulse exactly FILTER samples long
    add_run(4, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add_run(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    add_run(2, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add_run(2, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
    add_run(3, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add_run(4, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
    add_run(1, 4'b0011, 4'b0011, 4'b0010, 4'b0000);
    add_run(1, 4'b0011, 4'b0011, 4'b0000, 4'b0000);
    add_run(4, 4'b0111, 4'b0011, 4'b0000, 4'b0000);
    add_run(1, 4'b0111, 4'b0111, 4'b0100, 4'b0000);
    add_run(1, 4'b0111, 4'b0111, 4'b0000, 4'b0000);
    add_run(4, 4'b0010, 4'b0111, 4'b0000, 4'b0000);
    add_run(1, 4'b0010, 4'b0010, 4'b0000, 4'b0101);
    add_run(2, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    add_run(4, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    add_run(1, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add_run(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_run(3, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    add_run(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_run(1, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    add_run(2, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    add_run(1, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    add_run(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // reset at time zero, din toggling underneath it
    reset_n = 1'b0;
    din_a   = 4'b0000;
    din_b   = 4'b0000;
    #5;
    check("reset_imm_a", {3'b0, rsn_a, dout_a, rise_a, fall_a}, 16'h0000);
    check("reset_imm_b", {3'b0, rsn_b, dout_b, rise_b, fall_b}, 16'h0000);
    repeat (4) begin
      @(negedge clk);
      din_a = 4'($urandom_range(0, 15));
      din_b = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      check("reset_hold_a", {3'b0, rsn_a, dout_a, rise_a, fall_a}, 16'h0000);
      check("reset_hold_b", {3'b0, rsn_b, dout_b, rise_b, fall_b}, 16'h0000);
    end
    @(negedge clk);
    din_a   = 4'b0000;
    din_b   = 4'b0000;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("release_edge1", {3'b0, rsn_a, dout_a, rise_a, fall_a}, 16'h0000);
    @(posedge clk); #1;
    check("release_edge2", {3'b0, rsn_a, dout_a, rise_a, fall_a}, 16'h1000);
    check("release_edge2_b", {3'b0, rsn_b, dout_b, rise_b, fall_b}, 16'h1000);

    // table-driven vectors through the scoreboard
    prev_din_b  = 4'b0000;
    prev_dout_b = 4'b0000;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      din_a = vecs[i].din;
      din_b = vecs[i].din;
      exp_q.push_back({vecs[i].dout, vecs[i].rise, vecs[i].fall});
      push_b(vecs[i].din);
      @(posedge clk); #1;
      pop_check($sformatf("vec%0d", i), {dout_a, rise_a, fall_a}, {dout_b, rise_b, fall_b});
    end

    // reset while channel 0 is mid-count (count reaches 2 after the 4th edge)
    @(negedge clk);
    din_a = 4'b0001;
    din_b = 4'b0001;
    repeat (4) @(posedge clk);
    #5;
    reset_n = 1'b0;
    #1;
    check("midfilt_reset_a", {3'b0, rsn_a, dout_a, rise_a, fall_a}, 16'h0000);
    check("midfilt_reset_b", {3'b0, rsn_b, dout_b, rise_b, fall_b}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset_n     = 1'b1;
    prev_din_b  = 4'b0000;
    prev_dout_b = 4'b0000;
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back({(k >= 5) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000, 4'b0000});
      push_b(4'b0001);
      @(posedge clk); #1;
      check($sformatf("rsn_after_%0d", k), {15'b0, rsn_a}, (k >= 2) ? 16'h1 : 16'h0);
      pop_check($sformatf("refill%0d", k), {dout_a, rise_a, fall_a}, {dout_b, rise_b, fall_b});
    end

    // reset during a fall pulse on channel 0
    @(negedge clk);
    din_a = 4'b0000;
    din_b = 4'b0000;
    repeat (5) @(posedge clk);
    #1;
    check("pre_midpulse", {4'h0, dout_a, rise_a, fall_a}, 16'h0001);
    #4;
    reset_n = 1'b0;
    #1;
    check("midpulse_reset", {3'b0, rsn_a, dout_a, rise_a, fall_a}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_pulse_%0d", k), {3'b0, rsn_a, dout_a, rise_a, fall_a},
            (k >= 2) ? 16'h1000 : 16'h0000);
    end

    if (exp_q.size() != 0 || exp_b_q.size() != 0)
      check("scoreboard_drain", 16'(exp_q.size() + exp_b_q.size()), 16'h0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
